// File: rtl/dcache_data_arbiter.sv
// Single-port dcache data store controller: arbitrates refill, store and load
// requesters onto one SRAM port and returns load words with 1-cycle latency.
`timescale 1ns/1ps
module dcache_data_arbiter #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned NUM_WORDS    = 256,
  parameter int unsigned WORD_WIDTH   = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned ADDR_W  = $clog2(NUM_WORDS),
  localparam int unsigned NSLOT   = DATA_WIDTH / WORD_WIDTH,
  localparam int unsigned OFF_W   = (NSLOT > 1) ? $clog2(NSLOT) : 1,
  localparam int unsigned WBE_W   = WORD_WIDTH / 8,
  localparam int unsigned LBE_W   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  refill_req_i,
  output logic                  refill_gnt_o,
  input  logic [ADDR_W-1:0]     refill_addr_i,
  input  logic [DATA_WIDTH-1:0] refill_wdata_i,
  input  logic                  st_req_i,
  output logic                  st_gnt_o,
  input  logic [ADDR_W-1:0]     st_addr_i,
  input  logic [OFF_W-1:0]      st_off_i,
  input  logic [WORD_WIDTH-1:0] st_wdata_i,
  input  logic [WBE_W-1:0]      st_be_i,
  input  logic                  ld_req_i,
  output logic                  ld_gnt_o,
  input  logic [ADDR_W-1:0]     ld_addr_i,
  input  logic [OFF_W-1:0]      ld_off_i,
  input  logic                  ld_kill_i,
  output logic                  ld_rvalid_o,
  output logic [WORD_WIDTH-1:0] ld_rdata_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [LBE_W-1:0]      ram_be_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {SEL_NONE, SEL_REFILL, SEL_STORE, SEL_LOAD} sel_e;

  sel_e             sel;
  logic [3:0]       ld_wait_q;
  logic             starve_q;
  logic             rd_pend_q;
  logic [OFF_W-1:0] off_q;

  assign starve_q = (ld_wait_q == 4'(STARVE_LIMIT));

  // Grants are forced low while reset is asserted, independent of requests.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if (rst_ni) begin
      if (refill_req_i)                          sel = SEL_REFILL;
      else if (ld_req_i && (starve_q || !st_req_i)) sel = SEL_LOAD;
      else if (st_req_i)                         sel = SEL_STORE;
    end
  end

  assign refill_gnt_o = (sel == SEL_REFILL);
  assign st_gnt_o     = (sel == SEL_STORE);
  assign ld_gnt_o     = (sel == SEL_LOAD);

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    unique case (sel)
      SEL_REFILL: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_be_o    = '1;
        ram_addr_o  = refill_addr_i;
        ram_wdata_o = refill_wdata_i;
      end
      SEL_STORE: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_be_o    = LBE_W'(st_be_i) << (int'(st_off_i) * WBE_W);
        ram_addr_o  = st_addr_i;
        ram_wdata_o = {NSLOT{st_wdata_i}};
      end
      SEL_LOAD: begin
        ram_en_o   = 1'b1;
        ram_addr_o = ld_addr_i;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all state here
  // is a handful of flops, so every one of them is reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_wait_q <= '0;
      rd_pend_q <= 1'b0;
      off_q     <= '0;
    end else begin
      if (!ld_req_i || ld_gnt_o) ld_wait_q <= '0;
      else if (!starve_q)        ld_wait_q <= ld_wait_q + 4'd1;
      rd_pend_q <= ld_gnt_o;
      if (ld_gnt_o) off_q <= ld_off_i;
    end
  end

  // Kill only masks the response; the SRAM read already happened.
  assign ld_rvalid_o = rd_pend_q & ~ld_kill_i;
  assign ld_rdata_o  = ld_rvalid_o ? ram_rdata_i[int'(off_q) * WORD_WIDTH +: WORD_WIDTH] : '0;

endmodule

// File: tb/tb_dcache_data_arbiter.sv
// Directed bench for dcache_data_arbiter: per-cycle vector table plus
// hand-written starvation and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_dcache_data_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         refill_req_i, refill_gnt_o;
  logic [7:0]   refill_addr_i;
  logic [127:0] refill_wdata_i;
  logic         st_req_i, st_gnt_o;
  logic [7:0]   st_addr_i;
  logic [0:0]   st_off_i;
  logic [63:0]  st_wdata_i;
  logic [7:0]   st_be_i;
  logic         ld_req_i, ld_gnt_o;
  logic [7:0]   ld_addr_i;
  logic [0:0]   ld_off_i;
  logic         ld_kill_i, ld_rvalid_o;
  logic [63:0]  ld_rdata_o;
  logic         ram_en_o, ram_we_o;
  logic [15:0]  ram_be_o;
  logic [7:0]   ram_addr_o;
  logic [127:0] ram_wdata_o, ram_rdata_i;

  int checks = 0;
  int errors = 0;

  dcache_data_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o),
    .refill_addr_i(refill_addr_i), .refill_wdata_i(refill_wdata_i),
    .st_req_i(st_req_i), .st_gnt_o(st_gnt_o), .st_addr_i(st_addr_i),
    .st_off_i(st_off_i), .st_wdata_i(st_wdata_i), .st_be_i(st_be_i),
    .ld_req_i(ld_req_i), .ld_gnt_o(ld_gnt_o), .ld_addr_i(ld_addr_i),
    .ld_off_i(ld_off_i), .ld_kill_i(ld_kill_i), .ld_rvalid_o(ld_rvalid_o),
    .ld_rdata_o(ld_rdata_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port SRAM with registered read data.
  logic [127:0] mem [256];
  logic         init_done = 1'b0;
  always @(posedge clk_i) begin
    if (!init_done) begin
      mem[5]    <= {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
      mem[3]    <= {64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
      init_done <= 1'b1;
    end else if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 16; b++)
          if (ram_be_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  localparam logic [127:0] RF_X = 128'h0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [63:0]  RF_X_LO = 64'h0706050403020100;
  localparam logic [63:0]  ST_A = 64'h1122_3344_5566_7788;
  localparam logic [63:0]  ST_Y = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0]  ST_Z = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    logic [2:0]   req;      // {refill, st, ld}
    logic [7:0]   rf_addr;
    logic [127:0] rf_wdata;
    logic [7:0]   st_addr;
    logic [0:0]   st_off;
    logic [63:0]  st_wdata;
    logic [7:0]   st_be;
    logic [7:0]   ld_addr;
    logic [0:0]   ld_off;
    logic         ld_kill;
    logic [2:0]   gnt;      // {refill, st, ld}
    logic         en;
    logic         we;
    logic [15:0]  be;
    logic [7:0]   addr;
    logic [127:0] wdata;
    logic         rvalid;
    logic [63:0]  rdata;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    {refill_req_i, st_req_i, ld_req_i} = 3'b000;
    refill_addr_i = '0; refill_wdata_i = '0;
    st_addr_i = '0; st_off_i = '0; st_wdata_i = '0; st_be_i = '0;
    ld_addr_i = '0; ld_off_i = '0; ld_kill_i = 1'b0;
  endtask

  function automatic logic [2:0] gnts();
    return {refill_gnt_o, st_gnt_o, ld_gnt_o};
  endfunction

  initial begin
    // idx 0 idle; 1-2 load idx5/off1; 3-5 store then load idx3/off1;
    // 6-9 three-way contention; 10-13 hazards; 14-16 kill.
    tbl[0]  = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b0, 64'h0};
    tbl[1]  = '{3'b001, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd5, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 8'd5, 128'h0, 1'b0, 64'h0};
    tbl[2]  = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
    tbl[3]  = '{3'b010, 8'd0, 128'h0, 8'd3, 1'b1, ST_A, 8'h0F, 8'd0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 16'h0F00, 8'd3, {ST_A, ST_A}, 1'b0, 64'h0};
    tbl[4]  = '{3'b001, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd3, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 8'd3, 128'h0, 1'b0, 64'h0};
    tbl[5]  = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b1, 64'hCCCC_CCCC_5566_7788};
    tbl[6]  = '{3'b111, 8'd7, RF_X, 8'd2, 1'b0, ST_Y, 8'hFF, 8'd7, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 16'hFFFF, 8'd7, RF_X, 1'b0, 64'h0};
    tbl[7]  = '{3'b011, 8'd0, 128'h0, 8'd2, 1'b0, ST_Y, 8'hFF, 8'd7, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 16'h00FF, 8'd2, {ST_Y, ST_Y}, 1'b0, 64'h0};
    tbl[8]  = '{3'b001, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd7, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 8'd7, 128'h0, 1'b0, 64'h0};
    tbl[9]  = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b1, RF_X_LO};
    tbl[10] = '{3'b001, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd5, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 8'd5, 128'h0, 1'b0, 64'h0};
    tbl[11] = '{3'b010, 8'd0, 128'h0, 8'd5, 1'b0, ST_Z, 8'hFF, 8'd0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 16'h00FF, 8'd5, {ST_Z, ST_Z}, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB};
    tbl[12] = '{3'b001, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd5, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 8'd5, 128'h0, 1'b0, 64'h0};
    tbl[13] = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b1, ST_Z};
    tbl[14] = '{3'b001, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd5, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 8'd5, 128'h0, 1'b0, 64'h0};
    tbl[15] = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b0, 64'h0};
    tbl[16] = '{3'b000, 8'd0, 128'h0, 8'd0, 1'b0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd0, 128'h0, 1'b0, 64'h0};

    // Reset with every request raised: nothing may be granted.
    idle_inputs();
    rst_ni = 1'b0;
    {refill_req_i, st_req_i, ld_req_i} = 3'b111;
    @(negedge clk_i); #3;
    check("reset gnt", 128'(gnts()), 128'(3'b000));
    check("reset en", 128'(ram_en_o), 128'(1'b0));
    check("reset we", 128'(ram_we_o), 128'(1'b0));
    check("reset rvalid", 128'(ld_rvalid_o), 128'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();

    for (int i = 0; i < 17; i++) begin
      @(negedge clk_i);
      {refill_req_i, st_req_i, ld_req_i} = tbl[i].req;
      refill_addr_i = tbl[i].rf_addr; refill_wdata_i = tbl[i].rf_wdata;
      st_addr_i = tbl[i].st_addr; st_off_i = tbl[i].st_off;
      st_wdata_i = tbl[i].st_wdata; st_be_i = tbl[i].st_be;
      ld_addr_i = tbl[i].ld_addr; ld_off_i = tbl[i].ld_off; ld_kill_i = tbl[i].ld_kill;
      #3;
      check($sformatf("row%0d gnt", i), 128'(gnts()), 128'(tbl[i].gnt));
      check($sformatf("row%0d en", i), 128'(ram_en_o), 128'(tbl[i].en));
      check($sformatf("row%0d we", i), 128'(ram_we_o), 128'(tbl[i].we));
      check($sformatf("row%0d be", i), 128'(ram_be_o), 128'(tbl[i].be));
      check($sformatf("row%0d addr", i), 128'(ram_addr_o), 128'(tbl[i].addr));
      check($sformatf("row%0d wdata", i), ram_wdata_o, tbl[i].wdata);
      check($sformatf("row%0d rvalid", i), 128'(ld_rvalid_o), 128'(tbl[i].rvalid));
      check($sformatf("row%0d rdata", i), 128'(ld_rdata_o), 128'(tbl[i].rdata));
    end

    // Starvation: store and load both held; load wins once the counter
    // saturates, a refill still preempts a starved load.
    for (int c = 0; c < 11; c++) begin
      logic [2:0] exp_g;
      @(negedge clk_i);
      idle_inputs();
      st_req_i = 1'b1; st_addr_i = 8'd10; st_wdata_i = 64'h55; st_be_i = 8'h01;
      ld_req_i = 1'b1; ld_addr_i = 8'd11;
      if (c == 9) begin
        refill_req_i = 1'b1; refill_addr_i = 8'd12;
      end
      #3;
      if (c == 9)                exp_g = 3'b100;
      else if (c == 4 || c == 10) exp_g = 3'b001;
      else                       exp_g = 3'b010;
      check($sformatf("starve c%0d gnt", c), 128'(gnts()), 128'(exp_g));
      if (c == 5) check("starve rvalid after load", 128'(ld_rvalid_o), 128'(1'b1));
      if (c == 6) check("starve rvalid one shot", 128'(ld_rvalid_o), 128'(1'b0));
    end

    // Load granted, then reset lands in its response cycle.
    @(negedge clk_i);
    idle_inputs();
    ld_req_i = 1'b1; ld_addr_i = 8'd5; ld_off_i = 1'b1;
    #3;
    check("rst seq ld gnt", 128'(gnts()), 128'(3'b001));
    @(negedge clk_i);
    {refill_req_i, st_req_i, ld_req_i} = 3'b111;
    rst_ni = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("rst seq c%0d gnt", c), 128'(gnts()), 128'(3'b000));
      check($sformatf("rst seq c%0d en", c), 128'(ram_en_o), 128'(1'b0));
      check($sformatf("rst seq c%0d rvalid", c), 128'(ld_rvalid_o), 128'(1'b0));
      @(negedge clk_i);
    end
    rst_ni = 1'b1;
    refill_req_i = 1'b0;
    #3;
    check("post rst st beats ld", 128'(gnts()), 128'(3'b010));
    @(negedge clk_i);
    idle_inputs();
    ld_req_i = 1'b1; ld_addr_i = 8'd5; ld_off_i = 1'b1;
    #3;
    check("post rst no stale rvalid", 128'(ld_rvalid_o), 128'(1'b0));
    check("post rst ld gnt", 128'(gnts()), 128'(3'b001));
    @(negedge clk_i);
    idle_inputs();
    #3;
    check("post rst rvalid", 128'(ld_rvalid_o), 128'(1'b1));
    check("post rst rdata", 128'(ld_rdata_o), 128'(64'hAAAA_AAAA_AAAA_AAAA));

    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_data_arbiter.md
Name: dcache_data_arbiter

Overview:
- Single-port controller for the dcache data store SRAM: one line-wide write or read per cycle, 1-cycle read latency.
- Arbitrates three requesters:
  - refill: full-line write from the miss unit.
  - store: word write with byte enables, from the store unit.
  - load: word read, from the load unit.
- Sits between the dcache controller and the data store; owns all SRAM enable/write/byte-enable/address/data sequencing.

Parameters:
- DATA_WIDTH, 128, SRAM line width in bits (ariane_pkg::DCACHE_LINE_WIDTH).
- NUM_WORDS, 256, SRAM depth in lines (wt_cache_pkg::DCACHE_NUM_WORDS).
- WORD_WIDTH, 64, load/store word width; DATA_WIDTH must be a multiple of it.
- STARVE_LIMIT, 4, consecutive store-blocked cycles after which load outranks store (1..15).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- refill_req_i  in  1  refill write request.
- refill_gnt_o  out  1  refill granted this cycle.
- refill_addr_i  in  $clog2(NUM_WORDS)  refill line index.
- refill_wdata_i  in  DATA_WIDTH  refill line data.
- st_req_i  in  1  store request.
- st_gnt_o  out  1  store granted this cycle.
- st_addr_i  in  $clog2(NUM_WORDS)  store line index.
- st_off_i  in  $clog2(DATA_WIDTH/WORD_WIDTH)  word offset within line.
- st_wdata_i  in  WORD_WIDTH  store data.
- st_be_i  in  WORD_WIDTH/8  store byte enables.
- ld_req_i  in  1  load request.
- ld_gnt_o  out  1  load granted this cycle.
- ld_addr_i  in  $clog2(NUM_WORDS)  load line index.
- ld_off_i  in  $clog2(DATA_WIDTH/WORD_WIDTH)  load word offset.
- ld_kill_i  in  1  cancel the in-flight load response.
- ld_rvalid_o  out  1  load data valid.
- ld_rdata_o  out  WORD_WIDTH  load data word.
- ram_en_o  out  1  SRAM enable.
- ram_we_o  out  1  SRAM write (1) / read (0).
- ram_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- ram_addr_o  out  $clog2(NUM_WORDS)  SRAM line index.
- ram_wdata_o  out  DATA_WIDTH  SRAM write data.
- ram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read.

Behaviour:
- Grants are combinational in the request cycle; at most one gnt high per cycle.
- A requester holds req and its inputs stable until granted; the grant consumes the request.
- Priority:
  - refill always wins.
  - Otherwise store beats load, unless starve_q (ld_wait_q == STARVE_LIMIT), in which case load beats store.
- SRAM drive on grant:
  - refill: en=1, we=1, be=all ones, wdata=refill_wdata_i.
  - store: en=1, we=1, be = st_be_i shifted to byte lane st_off_i*WORD_WIDTH/8, others 0; wdata = st_wdata_i replicated across all word slots.
  - load: en=1, we=0, be=0.
  - no grant: en=0, we=0, be=0; addr/wdata don't-care, driven 0.
- Starvation counter ld_wait_q:
  - Increments when ld_req_i=1 and not granted, saturating at STARVE_LIMIT.
  - Clears on ld_gnt_o or when ld_req_i=0.
  - Cycles lost to refill also count; refill still preempts a starved load.
- Read pipeline:
  - On ld_gnt_o, register rd_pend_q=1 and off_q=ld_off_i.
  - Next cycle: ld_rvalid_o = rd_pend_q & ~ld_kill_i; ld_rdata_o = ram_rdata_i word slice off_q.
  - Latency exactly 1 cycle after grant; back-to-back loads give rvalid every cycle.
  - ld_rdata_o is 0 when ld_rvalid_o=0.
  - ld_kill_i is sampled only in the response cycle; it has no effect on grants.
- Hazards:
  - Write granted the cycle after a load to the same index: the load returns the old data. Required, since the SRAM reads before the write lands.
  - Load granted the cycle after a write returns the new data.
- Reset (async, rst_ni=0): ld_wait_q=0, rd_pend_q=0, off_q=0.
  - All grants and ram_en_o/ram_we_o are 0 while in reset, regardless of requests.
  - A load granted before a mid-operation reset produces no rvalid.
- Idle (no requests): all outputs 0.

Test Plan:
- Reset, ld_req at index 5 offset 1 with line 0xAAAA_..._BBBB_... at index 5 -> ld_gnt same cycle, ram_we=0, ld_rvalid next cycle with upper 64-bit word.
- st_req index 3, offset 1, be=0x0F, data 0x1122334455667788 -> ram_be=0x0F00, ram_we=1; following load of index 3 offset 1 -> low 4 bytes 0x55667788, upper bytes unchanged.
- refill, st, ld requests all high for one cycle -> refill_gnt only; the next cycle grants store.
- st_req held high for 10 cycles with ld_req high, STARVE_LIMIT=4 -> stores granted cycles 0-3, load granted cycle 4, counter cleared, stores resume.
- Load granted, ld_kill_i=1 in the response cycle -> ld_rvalid_o=0, ld_rdata_o=0.
- Load granted, rst_ni asserted in the next cycle -> no rvalid, all grants 0 during reset; normal arbitration resumes after release.
